// File: rtl/mem_arbiter.sv
// Fetch/data arbiter in front of a single-ported fixed-latency memory.
// Define MEM_ARB_STATS_EN to build the requester-conflict statistics counter.
module mem_arbiter #(
    parameter int LAT      = 2,
    parameter int MAX_WAIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [15:0] i_addr,
    output logic [15:0] i_rdata,
    output logic        i_done,
    input  logic        d_req,
    input  logic        d_wr,
    input  logic        d_dump,
    input  logic [15:0] d_addr,
    input  logic [15:0] d_wdata,
    output logic [15:0] d_rdata,
    output logic        d_done,
    output logic        m_en,
    output logic        m_wr,
    output logic        m_dump,
    output logic [15:0] m_addr,
    output logic [15:0] m_wdata,
    input  logic [15:0] m_rdata,
    output logic        busy,
    output logic [15:0] conflict_cnt,
    output logic        err
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;
    localparam int WW = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] LAT_INIT = CW'(LAT - 1);
    localparam logic [CW-1:0] LAT_ONE  = CW'(1);
    localparam logic [WW-1:0] WAIT_MAX = WW'(MAX_WAIT);
    localparam logic [WW-1:0] WAIT_ONE = WW'(1);

    state_t          state;
    state_t          state_nxt;
    logic            owner;      // 1 = data side owns the access
    logic [CW-1:0]   lat_cnt;
    logic [WW-1:0]   wait_cnt;
    logic            grant_d;
    logic            grant_i;

    // Arbitration and next-state decode
    always_comb begin
        state_nxt = state;
        grant_d   = 1'b0;
        grant_i   = 1'b0;
        case (state)
            IDLE: begin
                if (d_req && (!i_req || (wait_cnt < WAIT_MAX))) begin
                    grant_d   = 1'b1;
                    state_nxt = ACCESS;
                end else if (i_req) begin
                    grant_i   = 1'b1;
                    state_nxt = ACCESS;
                end else begin
                    state_nxt = IDLE;
                end
            end
            ACCESS: begin
                if (lat_cnt == {CW{1'b0}}) begin
                    state_nxt = DONE;
                end else begin
                    state_nxt = ACCESS;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Memory command, latency count, completion pulses and read data capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner   <= 1'b0;
            lat_cnt <= {CW{1'b0}};
            m_en    <= 1'b0;
            m_wr    <= 1'b0;
            m_dump  <= 1'b0;
            m_addr  <= 16'h0000;
            m_wdata <= 16'h0000;
            i_rdata <= 16'h0000;
            d_rdata <= 16'h0000;
            i_done  <= 1'b0;
            d_done  <= 1'b0;
            err     <= 1'b0;
        end else begin
            m_en   <= 1'b0;
            i_done <= 1'b0;
            d_done <= 1'b0;
            err    <= 1'b0;
            if (grant_d || grant_i) begin
                owner   <= grant_d;
                m_en    <= 1'b1;
                m_wr    <= grant_d & d_wr;
                m_dump  <= grant_d & d_dump;
                m_addr  <= grant_d ? d_addr : i_addr;
                m_wdata <= grant_d ? d_wdata : 16'h0000;
                lat_cnt <= LAT_INIT;
                // Unaligned address or a store that also asks for a dump
                err     <= (grant_d ? d_addr[0] : i_addr[0]) | (grant_d & d_wr & d_dump);
            end else if (state == ACCESS) begin
                if (lat_cnt == {CW{1'b0}}) begin
                    m_wr   <= 1'b0;
                    m_dump <= 1'b0;
                    if (owner) begin
                        d_done <= 1'b1;
                        if (!m_wr) begin
                            d_rdata <= m_rdata;
                        end
                    end else begin
                        i_done  <= 1'b1;
                        i_rdata <= m_rdata;
                    end
                end else begin
                    lat_cnt <= lat_cnt - LAT_ONE;
                end
            end
        end
    end

    // Fetch starvation counter: counts arbitrations fetch has lost in a row
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= {WW{1'b0}};
        end else if (!i_req || grant_i) begin
            wait_cnt <= {WW{1'b0}};
        end else if (grant_d && (wait_cnt < WAIT_MAX)) begin
            wait_cnt <= wait_cnt + WAIT_ONE;
        end
    end

    assign busy = (state != IDLE);

`ifdef MEM_ARB_STATS_EN
    logic [15:0] conflict_r;

    // Both sides asking means one of them is always waiting on the single port
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            conflict_r <= 16'h0000;
        end else if (i_req && d_req && (conflict_r != 16'hFFFF)) begin
            conflict_r <= conflict_r + 16'h0001;
        end
    end

    assign conflict_cnt = conflict_r;
`else
    assign conflict_cnt = 16'h0000;
`endif

endmodule
